// File: rtl/frame_sequencer.sv
// Frame-level sequencer for the dual-channel FFT amplitude-difference datapath.
// It resets the AD FIFOs and the datapath, waits for a full frame, lets the
// datapath drain it, and latches the root/magnitude result with its peak bin.
// A shared counter times the reset pulse and acts as the watchdog in the
// wait states.
module frame_sequencer #(
  parameter int DATA_NUM       = 2048,
  parameter int ADDR_WIDTH     = $clog2(DATA_NUM),
  parameter int RES_WIDTH      = 25,
  parameter int RST_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  single,
  input  logic                  abort,
  input  logic                  err_clr,
  input  logic                  fifo_rst_busy,
  input  logic                  fifo_full,
  input  logic                  fft_tlast,
  input  logic                  root_valid,
  input  logic [RES_WIDTH-1:0]  root_result,
  input  logic [ADDR_WIDTH-1:0] peak_addr,
  output logic                  fifo_rst,
  output logic                  dp_rst,
  output logic                  ad_fifo_ready,
  output logic                  busy,
  output logic                  result_valid,
  output logic [RES_WIDTH-1:0]  result_amp,
  output logic [ADDR_WIDTH-1:0] result_bin,
  output logic [15:0]           frame_cnt,
  output logic                  timeout_err
);

  // The counter must hold both the reset pulse length and the watchdog limit.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_RB   = 3'd2,
    ST_FILL      = 3'd3,
    ST_PROC      = 3'd4,
    ST_WAIT_ROOT = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             is_wait_s;
  logic             wd_hit_s;
  logic             timeout_s;
  logic             done_s;

  // Next-state decision: abort beats the watchdog, which beats normal progress.
  always_comb begin
    state_nx  = state;
    timeout_s = 1'b0;
    done_s    = 1'b0;
    is_wait_s = (state == ST_WAIT_RB) || (state == ST_FILL) ||
                (state == ST_PROC)    || (state == ST_WAIT_ROOT);
    wd_hit_s  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    if (abort) begin
      state_nx = ST_IDLE;
    end else if (is_wait_s && wd_hit_s) begin
      timeout_s = 1'b1;
      state_nx  = run ? ST_RESET : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run || single) state_nx = ST_RESET;
          else               state_nx = ST_IDLE;
        end
        ST_RESET: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) state_nx = ST_WAIT_RB;
          else                               state_nx = ST_RESET;
        end
        ST_WAIT_RB: begin
          if (!fifo_rst_busy) state_nx = ST_FILL;
          else                state_nx = ST_WAIT_RB;
        end
        ST_FILL: begin
          if (fifo_full) state_nx = ST_PROC;
          else           state_nx = ST_FILL;
        end
        ST_PROC: begin
          if (fft_tlast) state_nx = ST_WAIT_ROOT;
          else           state_nx = ST_PROC;
        end
        ST_WAIT_ROOT: begin
          if (root_valid) begin
            done_s   = 1'b1;
            state_nx = run ? ST_RESET : ST_IDLE;
          end else begin
            state_nx = ST_WAIT_ROOT;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // State, counter and registered outputs, all derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      fifo_rst      <= 1'b0;
      dp_rst        <= 1'b0;
      ad_fifo_ready <= 1'b0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      result_amp    <= '0;
      result_bin    <= '0;
      frame_cnt     <= 16'd0;
      timeout_err   <= 1'b0;
    end else begin
      state <= state_nx;
      // Counter restarts on every state entry and is idle-parked at zero.
      if ((state_nx != state) || (state_nx == ST_IDLE)) cnt <= '0;
      else                                              cnt <= cnt + CNT_W'(1);
      fifo_rst      <= (state_nx == ST_RESET);
      dp_rst        <= (state_nx == ST_RESET);
      ad_fifo_ready <= (state_nx == ST_PROC);
      busy          <= (state_nx != ST_IDLE);
      result_valid  <= done_s;
      if (done_s) begin
        result_amp <= root_result;
        result_bin <= peak_addr;
        frame_cnt  <= frame_cnt + 16'd1;
      end else begin
        result_amp <= result_amp;
        result_bin <= result_bin;
        frame_cnt  <= frame_cnt;
      end
      // A new timeout wins over a simultaneous clear.
      if (timeout_s)    timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      else              timeout_err <= timeout_err;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: frame-level scenarios with random
// waits and result values, checked against a transaction-level model.
module tb_frame_sequencer;

  localparam int RST_C = 8;
  localparam int TO_C  = 4096;

  logic        clk, rst, run, single, abort, err_clr;
  logic        fifo_rst_busy, fifo_full, fft_tlast, root_valid;
  logic [24:0] root_result;
  logic [10:0] peak_addr;
  logic        fifo_rst, dp_rst, ad_fifo_ready, busy, result_valid, timeout_err;
  logic [24:0] result_amp;
  logic [10:0] result_bin;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // Model: what the last completed frame should have left behind.
  logic [15:0] exp_cnt = 16'd0;
  logic [24:0] exp_amp = 25'd0;
  logic [10:0] exp_bin = 11'd0;

  frame_sequencer #(
    .DATA_NUM(2048), .RES_WIDTH(25), .RST_CYCLES(RST_C), .TIMEOUT_CYCLES(TO_C)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .single(single), .abort(abort),
    .err_clr(err_clr), .fifo_rst_busy(fifo_rst_busy), .fifo_full(fifo_full),
    .fft_tlast(fft_tlast), .root_valid(root_valid), .root_result(root_result),
    .peak_addr(peak_addr), .fifo_rst(fifo_rst), .dp_rst(dp_rst),
    .ad_fifo_ready(ad_fifo_ready), .busy(busy), .result_valid(result_valid),
    .result_amp(result_amp), .result_bin(result_bin), .frame_cnt(frame_cnt),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_single;
    single = 1'b1;
    tick();
    single = 1'b0;
  endtask

  // Counts the reset pulse starting from the first reset cycle.
  task automatic go_reset;
    int n;
    fifo_rst_busy = 1'b1;
    n = 0;
    while (fifo_rst === 1'b1 && n < 50) begin
      checks++; if (dp_rst !== 1'b1) begin errors++; $display("FAIL rst_dp got %0h exp 1", dp_rst); end
      n++;
      tick();
    end
    checks++; if (n != RST_C) begin errors++; $display("FAIL rst_len got %0d exp %0d", n, RST_C); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %0h exp 1", busy); end
  endtask

  // Holds the FIFO reset-busy flag for rb_wait cycles, then releases it.
  task automatic go_fill(input int rb_wait);
    for (int i = 0; i < rb_wait; i++) begin
      tick();
      checks++; if ({fifo_rst, ad_fifo_ready, busy} !== 3'b001) begin errors++; $display("FAIL waitrb_outs got %0b exp 001", {fifo_rst, ad_fifo_ready, busy}); end
    end
    fifo_rst_busy = 1'b0;
    tick();
  endtask

  task automatic go_proc(input int fill_wait);
    for (int i = 0; i < fill_wait; i++) begin
      checks++; if (ad_fifo_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0h exp 0", ad_fifo_ready); end
      tick();
    end
    fifo_full = 1'b1;
    tick();
    fifo_full = 1'b0;
    checks++; if (ad_fifo_ready !== 1'b1) begin errors++; $display("FAIL proc_ready got %0h exp 1", ad_fifo_ready); end
  endtask

  // Drains the frame, delivers the root result and checks the frame-end edge.
  task automatic finish(input int proc_len, input int root_wait,
                        input logic [24:0] amp, input logic [10:0] bin, input bit drop_run);
    logic cont;
    for (int i = 0; i < proc_len; i++) begin
      if (drop_run && i == 0) run = 1'b0;
      checks++; if (ad_fifo_ready !== 1'b1) begin errors++; $display("FAIL proc_hold got %0h exp 1", ad_fifo_ready); end
      tick();
    end
    fft_tlast = 1'b1;
    tick();
    fft_tlast = 1'b0;
    checks++; if (ad_fifo_ready !== 1'b0) begin errors++; $display("FAIL tlast_ready got %0h exp 0", ad_fifo_ready); end
    for (int i = 0; i < root_wait; i++) begin
      tick();
      checks++; if ({result_valid, busy} !== 2'b01) begin errors++; $display("FAIL root_wait got %0b exp 01", {result_valid, busy}); end
    end
    root_valid = 1'b1; root_result = amp; peak_addr = bin;
    cont = run;
    tick();
    root_valid = 1'b0; root_result = 25'($urandom()); peak_addr = 11'($urandom());
    exp_cnt = exp_cnt + 16'd1; exp_amp = amp; exp_bin = bin;
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL res_valid got %0h exp 1", result_valid); end
    checks++; if (result_amp !== exp_amp) begin errors++; $display("FAIL res_amp got %0h exp %0h", result_amp, exp_amp); end
    checks++; if (result_bin !== exp_bin) begin errors++; $display("FAIL res_bin got %0d exp %0d", result_bin, exp_bin); end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL frame_cnt got %0d exp %0d", frame_cnt, exp_cnt); end
    checks++; if ({busy, fifo_rst} !== {cont, cont}) begin errors++; $display("FAIL frame_end got %0b exp %0b", {busy, fifo_rst}, {cont, cont}); end
  endtask

  task automatic check_idle_after(input string tag);
    tick();
    checks++; if ({result_valid, busy, fifo_rst} !== 3'b000) begin errors++; $display("FAIL %s got %0b exp 000", tag, {result_valid, busy, fifo_rst}); end
  endtask

  task automatic test_reset;
    checks++; if ({fifo_rst, dp_rst, ad_fifo_ready, busy, result_valid, timeout_err} !== 6'b0) begin errors++; $display("FAIL reset_flags got %0b exp 0", {fifo_rst, dp_rst, ad_fifo_ready, busy, result_valid, timeout_err}); end
    checks++; if (result_amp !== 25'd0) begin errors++; $display("FAIL reset_amp got %0h exp 0", result_amp); end
    checks++; if (result_bin !== 11'd0) begin errors++; $display("FAIL reset_bin got %0h exp 0", result_bin); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0h exp 0", frame_cnt); end
  endtask

  task automatic test_single;
    pulse_single(); go_reset(); go_fill(3); go_proc(2048);
    finish(5, 4, 25'h00ABCDE, 11'd37, 1'b0);
    check_idle_after("single_idle");
  endtask

  task automatic test_random_frames;
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 5)) tick();
      pulse_single(); go_reset();
      go_fill($urandom_range(0, 6)); go_proc($urandom_range(0, 20));
      finish($urandom_range(1, 10), $urandom_range(0, 8), 25'($urandom()), 11'($urandom()), 1'b0);
      check_idle_after("rand_idle");
    end
  endtask

  task automatic test_continuous;
    logic [15:0] start_cnt;
    start_cnt = exp_cnt;
    run = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      go_reset(); go_fill($urandom_range(0, 4)); go_proc($urandom_range(0, 10));
      finish($urandom_range(1, 6), $urandom_range(0, 5), 25'($urandom()), 11'($urandom()), f == 2);
    end
    checks++; if (frame_cnt !== start_cnt + 16'd3) begin errors++; $display("FAIL cont_frames got %0d exp %0d", frame_cnt, start_cnt + 16'd3); end
    check_idle_after("cont_idle");
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (fifo_rst !== 1'b0) begin errors++; $display("FAIL cont_no_fourth got %0h exp 0", fifo_rst); end
    end
  endtask

  task automatic test_stray_strobes;
    root_valid = 1'b1; fft_tlast = 1'b1;
    tick();
    root_valid = 1'b0; fft_tlast = 1'b0;
    checks++; if ({result_valid, busy} !== 2'b00) begin errors++; $display("FAIL stray_idle got %0b exp 00", {result_valid, busy}); end
    pulse_single(); go_reset(); go_fill(2);
    root_valid = 1'b1; fft_tlast = 1'b1; single = 1'b1;
    tick();
    root_valid = 1'b0; fft_tlast = 1'b0; single = 1'b0;
    checks++; if ({result_valid, ad_fifo_ready, busy} !== 3'b001) begin errors++; $display("FAIL stray_fill got %0b exp 001", {result_valid, ad_fifo_ready, busy}); end
    go_proc(3);
    finish(2, 1, 25'($urandom()), 11'($urandom()), 1'b0);
    check_idle_after("stray_end");
  endtask

  task automatic test_abort;
    pulse_single(); go_reset(); go_fill(1); go_proc(2);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({ad_fifo_ready, busy, fifo_rst} !== 3'b000) begin errors++; $display("FAIL abort_outs got %0b exp 000", {ad_fifo_ready, busy, fifo_rst}); end
    fft_tlast = 1'b1; root_valid = 1'b1;
    tick();
    fft_tlast = 1'b0; root_valid = 1'b0;
    checks++; if ({result_valid, busy} !== 2'b00) begin errors++; $display("FAIL abort_ignored got %0b exp 00", {result_valid, busy}); end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL abort_cnt got %0d exp %0d", frame_cnt, exp_cnt); end
    checks++; if (result_amp !== exp_amp) begin errors++; $display("FAIL abort_amp got %0h exp %0h", result_amp, exp_amp); end
  endtask

  task automatic test_watchdog;
    int n;
    pulse_single(); go_reset(); go_fill(1);
    n = 0;
    while (timeout_err !== 1'b1 && n < TO_C + 100) begin
      tick();
      n++;
    end
    checks++; if (n != TO_C) begin errors++; $display("FAIL wd_cycles got %0d exp %0d", n, TO_C); end
    checks++; if ({busy, result_valid} !== 2'b00) begin errors++; $display("FAIL wd_idle got %0b exp 00", {busy, result_valid}); end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL wd_cnt got %0d exp %0d", frame_cnt, exp_cnt); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_clr got %0h exp 0", timeout_err); end
    // With run held the watchdog restarts the frame instead of idling.
    run = 1'b1;
    tick();
    go_reset(); go_fill(0);
    n = 0;
    while (timeout_err !== 1'b1 && n < TO_C + 100) begin
      tick();
      n++;
    end
    checks++; if (n != TO_C) begin errors++; $display("FAIL wd_run_cycles got %0d exp %0d", n, TO_C); end
    checks++; if ({fifo_rst, busy} !== 2'b11) begin errors++; $display("FAIL wd_run_restart got %0b exp 11", {fifo_rst, busy}); end
    run = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({busy, timeout_err} !== 2'b01) begin errors++; $display("FAIL wd_abort got %0b exp 01", {busy, timeout_err}); end
  endtask

  task automatic test_async_reset;
    pulse_single(); go_reset(); go_fill(0); go_proc(0);
    fft_tlast = 1'b1;
    tick();
    fft_tlast = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_cnt = 16'd0; exp_amp = 25'd0; exp_bin = 11'd0;
    checks++; if ({fifo_rst, dp_rst, ad_fifo_ready, busy, result_valid, timeout_err} !== 6'b0) begin errors++; $display("FAIL arst_flags got %0b exp 0", {fifo_rst, dp_rst, ad_fifo_ready, busy, result_valid, timeout_err}); end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL arst_cnt got %0d exp %0d", frame_cnt, exp_cnt); end
    checks++; if ({result_amp, result_bin} !== {exp_amp, exp_bin}) begin errors++; $display("FAIL arst_result got %0h exp 0", {result_amp, result_bin}); end
    tick();
    rst = 1'b0;
    tick();
    pulse_single(); go_reset(); go_fill(2); go_proc(4);
    finish(3, 2, 25'($urandom()), 11'($urandom()), 1'b0);
    check_idle_after("arst_frame");
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; single = 1'b0; abort = 1'b0; err_clr = 1'b0;
    fifo_rst_busy = 1'b1; fifo_full = 1'b0; fft_tlast = 1'b0; root_valid = 1'b0;
    root_result = 25'd0; peak_addr = 11'd0;
    tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_single();
    test_random_frames();
    test_continuous();
    test_stray_strobes();
    test_abort();
    test_watchdog();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame-level controller for the dual-channel FFT amplitude-difference datapath. It resets the two AD sample FIFOs and the processing chain, then waits for a full DATA_NUM-sample frame. It enables the datapath to drain the frame, waits for the root/magnitude result and latches it with the peak bin. It runs single-shot or back-to-back, with a watchdog on every wait state.

## Interface
Parameters:
- DATA_NUM, 2048, samples per frame (FFT length)
- ADDR_WIDTH, $clog2(DATA_NUM), peak-bin address width
- RES_WIDTH, 25, root result width
- RST_CYCLES, 8, fifo_rst/dp_rst pulse length in clocks (≥2)
- TIMEOUT_CYCLES, 65536, watchdog limit per wait state

Ports:
- clk  in  1  system clock
- rst  in  1  reset; **one clock; reset is asynchronous and active-high**
- run  in  1  level; high = continuous back-to-back frames
- single  in  1  one-cycle pulse; request exactly one frame
- abort  in  1  one-cycle pulse; drop current frame, go idle
- err_clr  in  1  pulse; clears timeout_err
- fifo_rst_busy  in  1  OR of AD FIFO wr/rd reset-busy flags
- fifo_full  in  1  both AD FIFOs hold ≥DATA_NUM samples
- fft_tlast  in  1  FFT output last-beat strobe
- root_valid  in  1  root result strobe
- root_result  in  RES_WIDTH  root magnitude
- peak_addr  in  ADDR_WIDTH  bin of the detected maximum
- fifo_rst  out  1  AD FIFO reset
- dp_rst  out  1  datapath (FFT/find-max) reset
- ad_fifo_ready  out  1  read enable for the datapath
- busy  out  1  high in any state except IDLE
- result_valid  out  1  one-cycle result strobe
- result_amp  out  RES_WIDTH  latched root_result
- result_bin  out  ADDR_WIDTH  latched peak_addr
- frame_cnt  out  16  completed frames, wraps 0xFFFF→0
- timeout_err  out  1  sticky watchdog flag

## Operation
- Moore FSM with states IDLE, RESET, WAIT_RB, FILL, PROC, WAIT_ROOT. All outputs are registered.
- IDLE: if run=1 or single=1, go to RESET. Store the request type (cont = run).
- RESET: fifo_rst=dp_rst=1 for exactly RST_CYCLES clocks (counter), then go to WAIT_RB.
- WAIT_RB: wait for fifo_rst_busy=0, then go to FILL.
- FILL: wait for fifo_full=1, then go to PROC.
- PROC: ad_fifo_ready=1. On fft_tlast, go to WAIT_ROOT. ad_fifo_ready drops the same edge.
- WAIT_ROOT: on root_valid, latch root_result/peak_addr, pulse result_valid, frame_cnt+1. Next state is RESET if run=1 at that edge, else IDLE.
- run is sampled only at frame end. Dropping run mid-frame finishes the frame, then goes to IDLE. single while busy is ignored.
- Watchdog: counter clears on every state entry and runs in WAIT_RB/FILL/PROC/WAIT_ROOT. When it reaches TIMEOUT_CYCLES-1, set timeout_err and go to RESET if run=1, else IDLE. No result and no frame_cnt increment.
- Priority at any edge: abort > timeout > normal transition.
- abort in any state goes to IDLE and deasserts all strobes. Latched results are kept.
- err_clr clears timeout_err. A simultaneous set wins.
- root_valid/fft_tlast outside WAIT_ROOT/PROC are ignored.

## Timing
- Reset values: state IDLE; fifo_rst, dp_rst, ad_fifo_ready, busy, result_valid, timeout_err = 0; result_amp, result_bin, frame_cnt = 0.
- Async rst forces these values immediately, including mid-frame. Deassertion restarts from IDLE.
- Request at edge N: busy and fifo_rst/dp_rst are high from N+1 through N+RST_CYCLES. WAIT_RB starts at N+RST_CYCLES+1.
- fifo_rst_busy low seen at edge M: FILL from M+1. fifo_full seen at edge K: ad_fifo_ready high from K+1.
- fft_tlast at edge T: ad_fifo_ready low from T+1.
- root_valid at edge R: result_valid high for cycle R+1 only; result_amp/bin/frame_cnt update at R+1.
  - Continuous mode: fifo_rst high again at R+1.
  - Single mode: busy low at R+1.
- Minimum frame period is RST_CYCLES+4 cycles plus the external waits.

## Test plan
- Single frame, RST_CYCLES=8: single pulse; busy_rst deasserts after 3 cycles; fifo_full after 2048 cycles; tlast; root_valid with 0x00ABCDE, peak 37 → fifo_rst high exactly 8 cycles; one result_valid; result_amp=0x00ABCDE, result_bin=37, frame_cnt=1, busy low.
- Continuous: run=1 for 3 frames, run dropped during frame 3 PROC → 3 result_valid pulses, frame_cnt=3, IDLE after third, no fourth fifo_rst.
- Watchdog, TIMEOUT_CYCLES=16: fifo_full held low → timeout_err set on 16th FILL cycle, no result, return to IDLE (run=0); err_clr → 0.
- Abort in PROC: abort pulse → ad_fifo_ready low next cycle, IDLE, later root_valid ignored, frame_cnt unchanged.
- Async reset mid-WAIT_ROOT: rst pulse between clock edges → all outputs reset immediately, frame_cnt=0; subsequent single completes normally.
- Stray strobes: root_valid and fft_tlast pulsed in IDLE and FILL → no state change, no result_valid.
